// File: rtl/mux_sel_reg_n.sv
// Registered N:1 W-bit mux with direct and auto-scan select; one cycle from sel/din to y.
// A y_valid/y_ready output stage holds y, y_ch and the scan position while downstream stalls.
module mux_sel_reg_n #(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*W-1:0]     din,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  input  logic               en,
  output logic [W-1:0]       y,
  output logic [SEL_W-1:0]   y_ch,
  output logic               y_valid,
  input  logic               y_ready
);

  localparam logic [16:0]      DWELL_C = 17'(DWELL);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);

  logic [W-1:0]     r_y;
  logic [SEL_W-1:0] r_y_ch;
  logic             r_valid;
  logic [SEL_W-1:0] r_scan_ch;
  logic [15:0]      r_dwell_cnt;
  logic             r_mode_q;

  logic             w_load;
  logic [SEL_W-1:0] w_base_ch;
  logic [15:0]      w_base_cnt;
  logic [SEL_W-1:0] w_ch;
  logic [16:0]      w_cnt_inc;
  logic             w_wrap;
  logic [W-1:0]     w_dat;

  always_comb begin
    w_load     = en && (!r_valid || y_ready);
    // Entering scan mode behaves as if the scan position were freshly reset.
    w_base_ch  = r_mode_q ? r_scan_ch : '0;
    w_base_cnt = r_mode_q ? r_dwell_cnt : '0;
    w_ch       = mode ? w_base_ch : sel;
    w_cnt_inc  = {1'b0, w_base_cnt} + 17'd1;
    w_wrap     = (w_cnt_inc == DWELL_C);
  end

  // Indices at or above N match no channel and yield zero.
  always_comb begin
    w_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (w_ch == SEL_W'(i)) begin
        w_dat = din[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y         <= '0;
      r_y_ch      <= '0;
      r_valid     <= 1'b0;
      r_scan_ch   <= '0;
      r_dwell_cnt <= '0;
      r_mode_q    <= 1'b0;
    end else if (w_load) begin
      r_y      <= w_dat;
      r_y_ch   <= w_ch;
      r_valid  <= 1'b1;
      r_mode_q <= mode;
      if (mode) begin
        if (w_wrap) begin
          r_dwell_cnt <= '0;
          r_scan_ch   <= (w_base_ch == LAST_CH) ? '0 : w_base_ch + SEL_W'(1);
        end else begin
          r_dwell_cnt <= w_cnt_inc[15:0];
          r_scan_ch   <= w_base_ch;
        end
      end
    end else if (y_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign y       = r_y;
  assign y_ch    = r_y_ch;
  assign y_valid = r_valid;

endmodule

// File: tb/tb_mux_sel_reg_n.sv
// Bench for mux_sel_reg_n: three parameterisations driven together, checked against a sample-count model.
module tb_mux_sel_reg_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, mode, y_ready;
  logic [31:0] m_din [3];
  logic [2:0]  m_sel [3];

  logic       y8;  logic [2:0] ych8; logic v8;
  logic [7:0] y4;  logic [1:0] ych4; logic v4;
  logic [1:0] y6;  logic [2:0] ych6; logic v6;

  mux_sel_reg_n #(.N(8), .W(1), .DWELL(4)) u8 (
    .clk(clk), .rst_n(rst_n), .din(m_din[0][7:0]), .sel(m_sel[0]), .mode(mode), .en(en),
    .y(y8), .y_ch(ych8), .y_valid(v8), .y_ready(y_ready));
  mux_sel_reg_n #(.N(4), .W(8), .DWELL(2)) u4 (
    .clk(clk), .rst_n(rst_n), .din(m_din[1][31:0]), .sel(m_sel[1][1:0]), .mode(mode), .en(en),
    .y(y4), .y_ch(ych4), .y_valid(v4), .y_ready(y_ready));
  mux_sel_reg_n #(.N(6), .W(2), .DWELL(3)) u6 (
    .clk(clk), .rst_n(rst_n), .din(m_din[2][11:0]), .sel(m_sel[2]), .mode(mode), .en(en),
    .y(y6), .y_ch(ych6), .y_valid(v6), .y_ready(y_ready));

  int P_N [3] = '{8, 4, 6};
  int P_W [3] = '{1, 8, 2};
  int P_D [3] = '{4, 2, 3};
  int P_S [3] = '{3, 2, 3};

  // Model: the k-th scan sample after entering scan mode comes from channel (k / DWELL) % N.
  int  e_y [3];
  int  e_ch [3];
  bit  e_v [3];
  bit  m_insc [3];
  int  m_k [3];
  bit  last_load0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int i, output logic [31:0] oy, output logic [31:0] och,
                         output logic [31:0] ov);
    case (i)
      0:       begin oy = 32'(y8); och = 32'(ych8); ov = 32'(v8); end
      1:       begin oy = 32'(y4); och = 32'(ych4); ov = 32'(v4); end
      default: begin oy = 32'(y6); och = 32'(ych6); ov = 32'(v6); end
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [31:0] oy, och, ov;
    for (int i = 0; i < 3; i++) begin
      get_obs(i, oy, och, ov);
      chk($sformatf("%s[%0d].y", tag, i), oy, 32'(e_y[i]));
      chk($sformatf("%s[%0d].y_ch", tag, i), och, 32'(e_ch[i]));
      chk($sformatf("%s[%0d].y_valid", tag, i), ov, 32'(e_v[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      e_y[i] = 0; e_ch[i] = 0; e_v[i] = 1'b0; m_insc[i] = 1'b0; m_k[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit ld;
    int ch, k;
    for (int i = 0; i < 3; i++) begin
      ld = en && (!e_v[i] || y_ready);
      if (i == 0) last_load0 = ld;
      if (ld) begin
        if (mode) begin
          k = m_insc[i] ? m_k[i] : 0;
          ch = (k / P_D[i]) % P_N[i];
          m_k[i] = k + 1;
        end else begin
          ch = int'(m_sel[i]) & ((1 << P_S[i]) - 1);
        end
        e_ch[i] = ch;
        e_y[i] = (ch < P_N[i]) ? int'((m_din[i] >> (ch * P_W[i])) & ((32'd1 << P_W[i]) - 1)) : 0;
        e_v[i] = 1'b1;
        m_insc[i] = mode;
      end else if (y_ready) begin
        e_v[i] = 1'b0;
      end
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Called 1 time unit after an edge: reset lands mid-cycle and is released before the next edge.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int n, stalls;
    logic [2:0] seq [$];

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin m_din[i] = '0; m_sel[i] = '0; end
    model_reset();
    #3;
    check_all("reset");
    #9;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Direct sweep on the 8-channel instance: channels alternate 1,0,...
    m_din[0] = 32'h55; m_din[1] = 32'h44332211; m_din[2] = 32'h0000_0E4B;
    en = 1'b1; y_ready = 1'b1; mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      m_sel[0] = 3'(s); m_sel[1] = 3'(s % 4); m_sel[2] = 3'(s);
      step("sweep");
      chk("sweep_y", 32'(y8), (s % 2 == 0) ? 32'd1 : 32'd0);
      chk("sweep_ch", 32'(ych8), 32'(s));
    end

    m_sel[1] = 3'd3; step("width");
    chk("width_y3", 32'(y4), 32'h44);
    m_sel[1] = 3'd0; step("width");
    chk("width_y0", 32'(y4), 32'h11);

    // Backpressure holds the sample until y_ready returns.
    m_sel[0] = 3'd2; step("bp");
    chk("bp_load_ch", 32'(ych8), 32'd2);
    y_ready = 1'b0; m_sel[0] = 3'd3;
    repeat (3) begin
      step("bp_stall");
      chk("bp_hold_ch", 32'(ych8), 32'd2);
      chk("bp_hold_y", 32'(y8), 32'd1);
    end
    y_ready = 1'b1; step("bp_release");
    chk("bp_rel_y", 32'(y8), 32'd0);
    chk("bp_rel_ch", 32'(ych8), 32'd3);

    // Out-of-range select on the 6-channel instance, then drop and held-valid.
    m_sel[2] = 3'd7; step("oor");
    chk("oor_y", 32'(y6), 32'd0);
    chk("oor_ch", 32'(ych6), 32'd7);
    chk("oor_v", 32'(v6), 32'd1);
    en = 1'b0; y_ready = 1'b1; step("drop");
    chk("drop_v", 32'(v6), 32'd0);
    chk("drop_ch", 32'(ych6), 32'd7);
    en = 1'b1; step("reload");
    en = 1'b0; y_ready = 1'b0; step("hold");
    chk("hold_v", 32'(v6), 32'd1);

    // Auto-scan with a 5-cycle stall after sample 10.
    mode = 1'b1; en = 1'b1; n = 0; stalls = 0;
    for (int it = 0; it < 200 && n < 33; it++) begin
      y_ready = !(n == 10 && stalls < 5);
      if (!y_ready) stalls++;
      for (int i = 0; i < 3; i++) m_din[i] = $urandom;
      step("scan");
      if (last_load0) begin
        seq.push_back(ych8);
        n++;
      end
    end
    chk("scan_count", 32'(n), 32'd33);
    for (int j = 0; j < seq.size(); j++)
      chk($sformatf("scan_seq%0d", j), 32'(seq[j]), 32'((j / 4) % 8));

    // Re-enter scan, reset at sample 13, then confirm restart from channel 0.
    y_ready = 1'b1; mode = 1'b0; step("pre_rst");
    mode = 1'b1;
    repeat (13) step("scan2");
    chk("scan13_ch", 32'(ych8), 32'd3);
    mid_reset("mid_rst");
    for (int s = 0; s < 5; s++) begin
      step("post_rst");
      chk("post_rst_ch", 32'(ych8), (s < 4) ? 32'd0 : 32'd1);
    end

    // Randomised traffic with occasional mode changes and resets.
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 3) != 0);
      y_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      for (int i = 0; i < 3; i++) begin
        m_sel[i] = 3'($urandom_range(0, 7));
        m_din[i] = $urandom;
      end
      step("rand");
      if ($urandom_range(0, 199) == 0) mid_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_sel_reg_n.md
Name: mux_sel_reg_n

Overview:
- Parametrised, registered N-channel, W-bit-wide multiplexer.
- Next generation of the team's 8:1 single-bit mux.
- Adds two select modes: direct select, and an auto-scan mode that visits every channel in turn with a programmable dwell.
- Adds a valid/ready output handshake with backpressure, for sampling sensor/status lines into downstream logic.

Parameters:
- N, 8, number of input channels (2..256).
- W, 1, bit width of each channel.
- DWELL, 4, accepted samples taken per channel before auto-scan advances (1..65535).
- SEL_W, $clog2(N) (localparam, minimum 1), width of the channel index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  N*W  flattened channels; channel i = din[i*W +: W].
- sel  input  SEL_W  channel index used in direct mode.
- mode  input  1  0 = direct select, 1 = auto-scan.
- en  input  1  request a new sample this cycle.
- y  output  W  registered selected channel data.
- y_ch  output  SEL_W  channel index that y was sampled from.
- y_valid  output  1  y/y_ch hold an unconsumed sample.
- y_ready  input  1  downstream accepts y this cycle.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately and mid-operation):
  - y=0, y_ch=0, y_valid=0.
  - scan_ch=0, dwell_cnt=0, mode_q=0.
- Definitions:
  - load = en && (!y_valid || y_ready).
  - ch = (mode ? scan_ch : sel).
- On load, at the rising edge:
  - y <= din[ch*W +: W], y_ch <= ch, y_valid <= 1.
  - Latency is one cycle from sel/din to y.
- Drop: on !en && y_ready, y_valid <= 0; y and y_ch keep their last values.
- Stall: on y_valid && !y_ready, y, y_ch, y_valid and all scan state hold, whatever en, sel, mode or din do.
- Out of range: in direct mode with sel >= N (non-power-of-2 N), a load gives y=0, y_ch=sel, y_valid=1. This is not an error.
- Scan state updates only on load with mode=1:
  - If mode_q==0 (entering scan), the sample comes from channel 0; afterwards scan_ch=0 and dwell_cnt=1.
  - Otherwise, dwell_cnt increments. When it reaches DWELL, dwell_cnt <= 0 and scan_ch <= (scan_ch==N-1) ? 0 : scan_ch+1.
  - Each channel therefore yields exactly DWELL consecutive samples. The wrap from N-1 to 0 is seamless.
- mode_q <= mode on every load.
- Direct-mode loads do not change scan_ch or dwell_cnt. Re-entering scan mode always restarts at channel 0.
- Simultaneous drop and load cannot occur: a load takes priority, and y_valid stays 1.
- din and sel are sampled only at load edges. Their changes between loads have no effect on the outputs.

Test Plan:
- Direct sweep: N=8, W=1, channels 0..7 = 1,0,1,0,1,0,1,0, en=1, y_ready=1, sel=0..7 one per cycle -> one cycle later y=1,0,1,0,1,0,1,0, y_ch=0..7, y_valid=1 throughout.
- Width: N=4, W=8, din channels = 0x11,0x22,0x33,0x44, sel=3 -> y=0x44, y_ch=3. Then sel=0 -> y=0x11.
- Backpressure: N=8, W=1 with the sweep data. Load sel=2 (y=1, y_ch=2), then y_ready=0 for 3 cycles while sel=3 -> y=1, y_ch=2 held. Raise y_ready -> next edge y=0, y_ch=3.
- Auto-scan: N=8, DWELL=4, mode=1, en=1, y_ready=1 -> y_ch = 0,0,0,0,1,1,1,1,...,7,7,7,7, then 0 on the 33rd sample. Inserting y_ready=0 for 5 cycles at sample 10 leaves the sequence unchanged, with no channel skipped.
- Out-of-range select and drop: N=6, sel=7 -> y=0, y_ch=7, y_valid=1. Then en=0, y_ready=1 -> y_valid=0 next edge with y/y_ch unchanged. en=0, y_ready=0 with y_valid=1 -> y_valid stays 1.
- Reset mid-scan: pull rst_n low between edges at sample 13 (y_ch=3) -> y=0, y_ch=0, y_valid=0 immediately. After release, the first scan load gives y_ch=0 and four samples of channel 0.
